// File: rtl/mq_ibuf2mac.sv
// mq_ibuf2mac: round-robin multi-queue ibuf ring reader feeding the MAC tx interface
module mq_ibuf2mac #(
  parameter int NQ = 4,
  parameter int QW = 2,
  parameter int BW = 9,
  parameter logic [15:0] MAXLEN = 16'd1518,
  parameter logic [15:0] MINLEN = 16'd14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NQ-1:0]          q_en,
  input  logic [NQ*(BW+1)-1:0]   committed_prod,
  output logic [NQ*(BW+1)-1:0]   committed_cons,
  output logic [QW+BW-1:0]       rd_addr,
  input  logic [63:0]            rd_data,
  output logic [63:0]            tx_data,
  output logic [7:0]             tx_data_valid,
  output logic                   tx_start,
  input  logic                   tx_ack,
  output logic                   tx_underrun,
  output logic [NQ-1:0]          q_err,
  output logic [31:0]            pkt_cnt
);
  typedef enum logic [2:0] {IDLE, HDR, PRE, START, STREAM, DONE} state_t;
  state_t state, state_nx;
  logic [BW:0] cons [NQ];
  logic [BW:0] prod [NQ];
  logic [BW:0] avail [NQ];
  logic [NQ-1:0] elig;
  logic [QW-1:0] rr, qid, sel;
  logic [BW-1:0] ptr;
  logic [7:0] nw, rem, lm;
  logic [2:0] lr;
  logic [15:0] len;
  logic [16:0] nw_c;
  logic bad;
  for (genvar g = 0; g < NQ; g++) begin : g_q
    assign prod[g] = committed_prod[g*(BW+1) +: BW+1];
    assign committed_cons[g*(BW+1) +: BW+1] = cons[g];
    assign avail[g] = prod[g] - cons[g];
    assign elig[g] = |avail[g] && q_en[g] && !q_err[g];
  end
  assign len = rd_data[15:0];
  assign nw_c = (17'(len) + 17'd7) >> 3;
  assign bad = len < MINLEN || len > MAXLEN || nw_c + 17'd1 > 17'(avail[qid]);
  assign lm = lr == 3'd0 ? 8'hFF : ~(8'hFF << lr);
  assign rd_addr = {qid, ptr};
  assign tx_underrun = 1'b0;
  // first eligible queue at or after rr, wrapping upward
  always_comb begin
    sel = rr;
    for (int k = NQ - 1; k >= 0; k--) if (elig[rr + QW'(k)]) sel = rr + QW'(k);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |elig ? HDR : IDLE;
      HDR:     state_nx = bad ? IDLE : PRE;
      PRE:     state_nx = START;
      START:   state_nx = tx_ack ? (rem == 8'd0 ? DONE : STREAM) : START;
      STREAM:  state_nx = rem == 8'd0 ? DONE : STREAM;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // frame start request is held for the whole START state
  always_comb tx_start = state == START;
  // read pointer, tx datapath, per-queue pointers, error flags and counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NQ; i++) cons[i] <= '0;
      qid <= '0;
      ptr <= '0;
      rr <= '0;
      nw <= '0;
      rem <= '0;
      lr <= '0;
      tx_data <= '0;
      tx_data_valid <= '0;
      q_err <= '0;
      pkt_cnt <= '0;
    end else case (state)
      IDLE: if (|elig) begin
        qid <= sel;
        ptr <= cons[sel][BW-1:0];
      end
      HDR: if (bad) begin
        q_err[qid] <= 1'b1;
        rr <= qid + QW'(1);
      end else begin
        nw <= nw_c[7:0];
        lr <= len[2:0];
        ptr <= ptr + BW'(1);
      end
      PRE: begin
        tx_data <= rd_data;
        tx_data_valid <= nw == 8'd1 ? lm : 8'hFF;
        rem <= nw - 8'd1;
        ptr <= ptr + BW'(1);
      end
      START, STREAM: if (state == STREAM || tx_ack) begin
        if (rem != 8'd0) begin
          tx_data <= rd_data;
          tx_data_valid <= rem == 8'd1 ? lm : 8'hFF;
          rem <= rem - 8'd1;
          ptr <= ptr + BW'(1);
        end else tx_data_valid <= '0;
      end
      DONE: begin
        cons[qid] <= cons[qid] + (BW+1)'(nw) + (BW+1)'(1);
        pkt_cnt <= pkt_cnt + 32'd1;
        rr <= qid + QW'(1);
      end
      default: ;
    endcase
endmodule

// File: tb/tb_mq_ibuf2mac.sv
// tb_mq_ibuf2mac: randomized frame traffic against a queue-level reference model
module tb_mq_ibuf2mac;
  localparam int NQ = 4, QW = 2, BW = 9, RS = 512, PW = 1024;
  logic clk = 0, rst_n = 1, tx_ack = 0;
  logic [NQ-1:0] q_en = 0, q_err;
  logic [NQ*(BW+1)-1:0] committed_prod = 0, committed_cons;
  logic [QW+BW-1:0] rd_addr;
  logic [63:0] rd_data, tx_data;
  logic [7:0] tx_data_valid;
  logic tx_start, tx_underrun;
  logic [31:0] pkt_cnt;
  logic [63:0] mem [NQ*RS];
  assign rd_data = mem[rd_addr];
  always #5 clk = ~clk;
  mq_ibuf2mac #(.NQ(NQ), .QW(QW), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .q_en(q_en), .committed_prod(committed_prod),
    .committed_cons(committed_cons), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_start(tx_start),
    .tx_ack(tx_ack), .tx_underrun(tx_underrun), .q_err(q_err), .pkt_cnt(pkt_cnt)
  );
  int checks = 0, errors = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct {int q; int ptr; int len;} fr_t;
  fr_t exp_q[$];
  int pend[NQ][$];
  int prod_m[NQ], cons_m[NQ], pkt_m = 0, rr_m = 0;
  logic [NQ-1:0] err_m = 0, poison = 0;
  function automatic int words(int len);
    return (len + 7) / 8;
  endfunction
  function automatic logic [7:0] mask_of(int len, int k);
    return (k == words(len) - 1 && len % 8 != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF;
  endfunction
  function automatic int free_of(int q);
    return RS - (prod_m[q] - cons_m[q] + PW) % PW;
  endfunction
  task automatic load(int q, int len, int adv);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[15:0] = 16'(len);
    mem[q*RS + prod_m[q] % RS] = h;
    for (int k = 1; k < adv; k++) mem[q*RS + (prod_m[q] + k) % RS] = {$urandom, $urandom};
    if (len < 14 || len > 1518 || adv != 1 + words(len)) poison[q] = 1'b1;
    pend[q].push_back(len);
    prod_m[q] = (prod_m[q] + adv) % PW;
    committed_prod[q*(BW+1) +: BW+1] = 10'(prod_m[q]);
  endtask
  task automatic plan(logic [NQ-1:0] en);
    int q, c, len, need, avail;
    bit hit;
    do begin
      hit = 0;
      q = 0;
      for (int k = 0; k < NQ; k++) begin
        c = (rr_m + k) % NQ;
        if (!hit && en[c] && !err_m[c] && pend[c].size() > 0) begin
          hit = 1;
          q = c;
        end
      end
      if (hit) begin
        len = pend[q].pop_front();
        need = 1 + words(len);
        avail = (prod_m[q] - cons_m[q] + PW) % PW;
        if (len < 14 || len > 1518 || need > avail) err_m[q] = 1'b1;
        else begin
          exp_q.push_back('{q, cons_m[q], len});
          cons_m[q] = (cons_m[q] + need) % PW;
          pkt_m++;
        end
        rr_m = (q + 1) % NQ;
      end
    end while (hit);
  endtask
  task automatic recv(fr_t e, int dly);
    int t = 0, n = words(e.len), d;
    logic [63:0] w0;
    while (tx_start !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", 64'(t < 4000), 1);
    if (t >= 4000) return;
    check("rd_addr_start", 64'(rd_addr), 64'(e.q*RS + (e.ptr + 2) % RS));
    w0 = mem[e.q*RS + (e.ptr + 1) % RS];
    check("word0", tx_data, w0);
    check("mask0", 64'(tx_data_valid), 64'(mask_of(e.len, 0)));
    d = dly < 0 ? int'($urandom_range(0, 7)) : dly;
    repeat (d) begin
      @(negedge clk);
      check("hold_start", 64'(tx_start), 1);
      check("hold_data", tx_data, w0);
    end
    tx_ack = 1;
    @(negedge clk);
    tx_ack = 0;
    check("start_drop", 64'(tx_start), 0);
    for (int k = 1; k < n; k++) begin
      check("word", tx_data, mem[e.q*RS + (e.ptr + 1 + k) % RS]);
      check("mask", 64'(tx_data_valid), 64'(mask_of(e.len, k)));
      @(negedge clk);
    end
    check("end_mask", 64'(tx_data_valid), 0);
  endtask
  task automatic go(logic [NQ-1:0] en, int dly);
    fr_t e;
    plan(en);
    q_en = en;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      recv(e, dly);
    end
    repeat (30) @(negedge clk);
    for (int q = 0; q < NQ; q++) check("cons", 64'(committed_cons[q*(BW+1) +: BW+1]), 64'(cons_m[q]));
    check("q_err", 64'(q_err), 64'(err_m));
    check("pkt_cnt", 64'(pkt_cnt), 64'(pkt_m));
    check("idle_start", 64'(tx_start), 0);
    q_en = 0;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int t, k, w, len, adv, r;
    for (int i = 0; i < NQ*RS; i++) mem[i] = {$urandom, $urandom};
    for (int q = 0; q < NQ; q++) begin
      prod_m[q] = 0;
      cons_m[q] = 0;
    end
    #3 rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_cons", 64'(committed_cons), 0);
    check("rst_rd_addr", 64'(rd_addr), 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_valid", 64'(tx_data_valid), 0);
    check("rst_start", 64'(tx_start), 0);
    check("rst_underrun", 64'(tx_underrun), 0);
    check("rst_q_err", 64'(q_err), 0);
    check("rst_pkt", 64'(pkt_cnt), 0);
    rst_n = 1;
    load(0, 200, 26);
    q_en = 4'b0001;
    t = 0;
    while (tx_start !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_rst_start", 64'(t < 100), 1);
    tx_ack = 1;
    @(negedge clk);
    tx_ack = 0;
    repeat (4) @(negedge clk);
    check("mid_rst_streaming", 64'(tx_data_valid), 8'hFF);
    rst_n = 0;
    #1;
    check("mid_rst_valid", 64'(tx_data_valid), 0);
    check("mid_rst_data", tx_data, 0);
    check("mid_rst_rd_addr", 64'(rd_addr), 0);
    check("mid_rst_cons", 64'(committed_cons), 0);
    @(negedge clk);
    q_en = 0;
    rst_n = 1;
    go(4'b1111, -1);
    load(0, 64, 9);
    go(4'b1111, 0);
    load(0, 60, 9);
    load(1, 60, 9);
    load(3, 60, 9);
    go(4'b1111, -1);
    load(1, 2000, 1);
    load(2, 100, 14);
    go(4'b1111, -1);
    check("malformed_q_err", 64'(q_err), 4'b0010);
    load(3, 8, 2);
    go(4'b1111, 7);
    load(0, 100, 14);
    go(4'b1111, 7);
    while (cons_m[2] % RS != 510) begin
      k = (510 - cons_m[2] % RS + RS) % RS;
      if (k < 3) k += RS;
      w = k >= 193 ? 190 : (k <= 190 ? k : k - 3);
      load(2, 8 * (w - 1), w);
      go(4'b0100, 0);
    end
    load(2, 24, 4);
    go(4'b0100, -1);
    check("wrap_cons2_idx", 64'(committed_cons[2*(BW+1) +: BW]), 2);
    for (int ep = 0; ep < 40; ep++) begin
      for (int q = 0; q < NQ; q++) begin
        for (int f = int'($urandom_range(0, 3)); f > 0; f--) begin
          r = $urandom_range(0, 199);
          if (r == 0) begin
            len = $urandom_range(1519, 4000);
            adv = 1;
          end else if (r == 1) begin
            len = $urandom_range(0, 13);
            adv = 1;
          end else if (r == 2) begin
            len = $urandom_range(100, 300);
            adv = 2;
          end else begin
            len = r < 20 ? int'($urandom_range(900, 1518)) : int'($urandom_range(14, 200));
            adv = 1 + words(len);
          end
          if (poison[q] || free_of(q) < adv) break;
          load(q, len, adv);
        end
      end
      go(4'($urandom_range(1, 15)), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mq_ibuf2mac.md
Name: mq_ibuf2mac

Overview:
- Multi-queue successor to the single-queue ibuf-to-MAC consumer in the tx path. Runs in the MAC clock domain.
- Reads whole frames from one internal buffer that is split into NQ equal per-queue rings. Picks the next queue with a round-robin arbiter at frame boundaries and streams the frame to the MAC tx interface.
- Keeps one committed-consumer pointer per queue, returned to the PCIe side via per-queue synchronisers.
- Adds queue enables, malformed-header detection with per-queue sticky error, and a frame counter.

Parameters:
- NQ, 4, number of queues; must be a power of two, 1..8.
- QW, 2, log2(NQ).
- BW, 9, per-queue ring address bits; each ring holds 2^BW qwords.
- MAXLEN, 16'd1518, largest legal frame in bytes.
- MINLEN, 16'd14, smallest legal frame in bytes.

Ports:
- clk  in  1  MAC clock.
- rst_n  in  1  reset, asynchronous, active-low.
- q_en  in  NQ  per-queue enable, static while a queue is non-empty.
- committed_prod  in  NQ*(BW+1)  per-queue producer pointers, already synchronised; queue i occupies bits [i*(BW+1) +: BW+1].
- committed_cons  out  NQ*(BW+1)  per-queue consumer pointers, same packing.
- rd_addr  out  QW+BW  ibuf read address = {qid, ptr[BW-1:0]}.
- rd_data  in  64  ibuf read data; valid one clk after rd_addr.
- tx_data  out  64  MAC tx data.
- tx_data_valid  out  8  byte-valid mask.
- tx_start  out  1  frame start request.
- tx_ack  in  1  MAC accepts the frame; data must flow the next cycle.
- tx_underrun  out  1  abort the current frame.
- q_err  out  NQ  sticky per-queue malformed-header flag.
- pkt_cnt  out  32  frames transmitted, wraps.

Behaviour:
- Reset (async assert, sync deassert): committed_cons=0, rd_addr=0, tx_data=0, tx_data_valid=0, tx_start=0, tx_underrun=0, q_err=0, pkt_cnt=0, rr pointer=0, state=IDLE.
- Ring format: one header qword, then ceil(len/8) data qwords, little-endian bytes. Header [15:0] = len in bytes; other header bits are ignored.
- Producer contract: committed_prod only advances by whole frames.
- avail_i = (committed_prod_i - cons_i) mod 2^(BW+1). Queue i is eligible when avail_i != 0 and q_en[i] and !q_err[i].
- Pointer arithmetic is BW+1 bits and wraps naturally. The ring index is ptr[BW-1:0].

State machine:
- IDLE:
  - If any queue is eligible, select the first eligible queue starting at rr and scanning upward mod NQ.
  - Drive rd_addr = header address -> HDR.
- HDR: rd_data holds the header.
  - If len<MINLEN, len>MAXLEN, or 1+ceil(len/8) > avail_qid: set q_err[qid], leave cons unchanged, rr=qid+1 -> IDLE.
  - Otherwise drive rd_addr = first data address -> PRE.
- PRE: capture rd_data into tx_data, assert tx_start=1 -> START.
- START:
  - Hold tx_start and tx_data, keep rd_addr on the second data word, until tx_ack.
  - On tx_ack: tx_start=0. tx_data shows the next word from the cycle after ack onward. A 1-qword frame (len<=8) was already shown in PRE, so it ends at ack.
- STREAM:
  - One qword per clk with no gaps; rd_addr runs one cycle ahead.
  - tx_data_valid=8'hFF on full words. On the last word the mask = (1<<r)-1 with r=len[2:0], or 8'hFF when r=0.
  - After the last word -> DONE.
- DONE:
  - tx_data_valid=0.
  - cons_qid += 1+ceil(len/8), registered here.
  - pkt_cnt += 1, rr=qid+1 -> IDLE.
  - At least 1 idle clk separates frames.
- Address wrap inside a frame: the ring index wraps 2^BW-1 -> 0 with no bubble.
- tx_underrun is held 0 (ring data is always present). It is reserved and driven low.
- Deasserting q_en mid-frame does not abort the frame; it takes effect at the next arbitration.
- q_err clears only on reset. Other queues are unaffected by one queue's error.
- Async reset mid-frame drops all outputs to reset values immediately. The MAC sees an aborted frame.
- Throughput: back-to-back frames from different queues are separated by IDLE+HDR+PRE+START(>=1)+DONE overhead (5 clk minimum).

Test Plan:
- Single frame, NQ=4, q0 holds len=64 -> tx_start; after ack, 8 words with mask FF. cons0=9, pkt_cnt=1, other cons=0.
- Round robin: q0, q1 and q3 each hold one len=60 frame -> transmit order q0, q1, q3. Last-word mask 8'h0F. Final cons = 9, 9, 0, 9.
- Wrap: cons2=prod-ptr at ring index 510 (BW=9) with a len=24 frame -> rd_addr index sequence 510, 511, 0, 1. Data is contiguous on tx_data and cons2 wraps to index 2.
- Malformed: q1 header len=2000 -> no tx_start, q_err=4'b0010, cons1 unchanged. q2's pending frame is still sent next.
- tx_ack delayed 7 clk -> tx_start and tx_data stay stable for 7 clk, then data streams with no gap. A len=8 frame shows mask FF for one cycle only.
- Async rst_n low mid-STREAM -> all outputs 0 in the same cycle. After release, the frame is resent from its header, since cons was never advanced.
